// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard status and stage-register control bundle between the
// datapath (master) and the hazard sequencing controller (slave).
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       ifid_RS1;
    logic [4:0]       ifid_RS2;
    logic             ifid_use_rs1;
    logic             ifid_use_rs2;
    logic [4:0]       idex_rd;
    logic             idex_MemRead;
    logic             ex_mispredict;
    logic             ex_mc_op;
    logic             mc_done;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             pc_sel;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             mc_start;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ifid_RS1, ifid_RS2, ifid_use_rs1, ifid_use_rs2, idex_rd,
               idex_MemRead, ex_mispredict, ex_mc_op, mc_done, mem_req,
               mem_ready,
        input  pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_flush, mc_start, mem_timeout,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  ifid_RS1, ifid_RS2, ifid_use_rs1, ifid_use_rs2, idex_rd,
               idex_MemRead, ex_mispredict, ex_mc_op, mc_done, mem_req,
               mem_ready,
        output pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_flush, mc_start, mem_timeout,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard sequencing controller for the 5-stage RV32I pipeline: stalls, flushes,
// PC redirect select, multi-cycle/LSU wait handling and perf counters.
module hazard_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic         i_clk,
    input  logic         i_reset,
    hazard_ctrl_if.slave hz
);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MC_BUSY, MEM_WAIT} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_load_use;
    logic w_mem_stall;
    logic w_ex_eval;
    logic w_pc_en, w_pc_sel, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush;
    logic w_exmem_en, w_exmem_flush, w_memwb_flush, w_mc_start;

    assign w_load_use  = hz.idex_MemRead && (hz.idex_rd != 5'd0) &&
                         ((hz.ifid_use_rs1 && (hz.idex_rd == hz.ifid_RS1)) ||
                          (hz.ifid_use_rs2 && (hz.idex_rd == hz.ifid_RS2)));
    assign w_mem_stall = hz.mem_req && !hz.mem_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_next = MEM_WAIT;
                end else if (!hz.ex_mispredict && hz.ex_mc_op) begin
                    w_next = MC_BUSY;
                end
            end
            MC_BUSY: begin
                if (hz.mc_done) begin
                    w_next = RUN;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready) begin
                    w_next = (!hz.ex_mispredict && hz.ex_mc_op) ? MC_BUSY : RUN;
                end
            end
            default: w_next = RUN;
        endcase
    end

    // RUN and the MEM_WAIT release cycle share one EX/ID priority evaluation.
    always_comb begin
        w_pc_en       = 1'b1;
        w_pc_sel      = 1'b0;
        w_ifid_en     = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_en     = 1'b1;
        w_idex_flush  = 1'b0;
        w_exmem_en    = 1'b1;
        w_exmem_flush = 1'b0;
        w_memwb_flush = 1'b0;
        w_mc_start    = 1'b0;
        w_ex_eval     = 1'b0;
        if (!i_reset) begin
            unique case (r_state)
                RUN, MEM_WAIT: begin
                    if ((r_state == RUN) ? w_mem_stall : !hz.mem_ready) begin
                        w_pc_en       = 1'b0;
                        w_ifid_en     = 1'b0;
                        w_idex_en     = 1'b0;
                        w_exmem_en    = 1'b0;
                        w_memwb_flush = 1'b1;
                    end else begin
                        w_ex_eval = 1'b1;
                    end
                end
                MC_BUSY: begin
                    if (!hz.mc_done) begin
                        w_pc_en       = 1'b0;
                        w_ifid_en     = 1'b0;
                        w_idex_en     = 1'b0;
                        w_exmem_flush = 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_ex_eval) begin
                if (hz.ex_mispredict) begin
                    w_pc_sel     = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                end else if (hz.ex_mc_op) begin
                    w_mc_start    = 1'b1;
                    w_pc_en       = 1'b0;
                    w_ifid_en     = 1'b0;
                    w_idex_en     = 1'b0;
                    w_exmem_flush = 1'b1;
                end else if (w_load_use) begin
                    w_pc_en      = 1'b0;
                    w_ifid_en    = 1'b0;
                    w_idex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_pc_sel && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            if ((r_state == MEM_WAIT) && !hz.mem_ready) begin
                if (r_wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                if (r_wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign hz.pc_en       = w_pc_en;
    assign hz.pc_sel      = w_pc_sel;
    assign hz.ifid_en     = w_ifid_en;
    assign hz.ifid_flush  = w_ifid_flush;
    assign hz.idex_en     = w_idex_en;
    assign hz.idex_flush  = w_idex_flush;
    assign hz.exmem_en    = w_exmem_en;
    assign hz.exmem_flush = w_exmem_flush;
    assign hz.memwb_flush = w_memwb_flush;
    assign hz.mc_start    = w_mc_start;
    assign hz.mem_timeout = r_timeout;
    assign hz.stall_cnt   = r_stall_cnt;
    assign hz.flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected control vectors and counters are
// queued per driven cycle and compared against the DUT before the next edge.
module tb_hazard_ctrl;
    localparam int unsigned CW = 3;

    // {pc_en,pc_sel,ifid_en,ifid_flush,idex_en,idex_flush,exmem_en,exmem_flush,memwb_flush,mc_start}
    localparam logic [9:0] DEF = 10'b1010101000;
    localparam logic [9:0] LU  = 10'b0000111000;
    localparam logic [9:0] MP  = 10'b1111111000;
    localparam logic [9:0] MCS = 10'b0000001101;
    localparam logic [9:0] MCB = 10'b0000001100;
    localparam logic [9:0] MW  = 10'b0000000010;

    typedef struct {
        logic [9:0]    ctl;
        logic          to;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        bit            chk;
        string         tag;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   checks;
    int   errors;
    logic          exp_to;
    logic [CW-1:0] exp_stall;
    logic [CW-1:0] exp_flush;

    hazard_ctrl_if #(.CNT_W(CW)) hz ();

    hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(4)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .hz      (hz.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        hz.ifid_RS1      = 5'd0;
        hz.ifid_RS2      = 5'd0;
        hz.ifid_use_rs1  = 1'b0;
        hz.ifid_use_rs2  = 1'b0;
        hz.idex_rd       = 5'd0;
        hz.idex_MemRead  = 1'b0;
        hz.ex_mispredict = 1'b0;
        hz.ex_mc_op      = 1'b0;
        hz.mc_done       = 1'b0;
        hz.mem_req       = 1'b0;
        hz.mem_ready     = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        hz.idex_MemRead = 1'b1;
        hz.idex_rd      = rd;
        hz.ifid_RS1     = rs1;
        hz.ifid_use_rs1 = u1;
        hz.ifid_RS2     = rs2;
        hz.ifid_use_rs2 = u2;
    endtask

    task automatic check_out();
        exp_t       e;
        logic [9:0] obs;
        e   = sb.pop_front();
        obs = {hz.pc_en, hz.pc_sel, hz.ifid_en, hz.ifid_flush, hz.idex_en,
               hz.idex_flush, hz.exmem_en, hz.exmem_flush, hz.memwb_flush, hz.mc_start};
        checks++;
        assert (obs === e.ctl) else begin
            errors++;
            $error("FAIL %s ctl: got %b expected %b", e.tag, obs, e.ctl);
        end
        if (e.chk) begin
            checks++;
            assert (hz.mem_timeout === e.to) else begin
                errors++;
                $error("FAIL %s mem_timeout: got %b expected %b", e.tag, hz.mem_timeout, e.to);
            end
            checks++;
            assert (hz.stall_cnt === e.sc) else begin
                errors++;
                $error("FAIL %s stall_cnt: got %0d expected %0d", e.tag, hz.stall_cnt, e.sc);
            end
            checks++;
            assert (hz.flush_cnt === e.fc) else begin
                errors++;
                $error("FAIL %s flush_cnt: got %0d expected %0d", e.tag, hz.flush_cnt, e.fc);
            end
        end
    endtask

    // Inputs are already driven (at a negedge); queue expectation, sample, advance.
    task automatic step(input logic [9:0] ev, input string tag);
        exp_t e;
        e.ctl = ev;
        e.to  = exp_to;
        e.sc  = exp_stall;
        e.fc  = exp_flush;
        e.chk = !rst;
        e.tag = tag;
        sb.push_back(e);
        if (!rst) begin
            if (!ev[9] && (exp_stall != '1)) exp_stall = exp_stall + 1'b1;
            if (ev[8] && (exp_flush != '1)) exp_flush = exp_flush + 1'b1;
        end
        #2;
        check_out();
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        step(DEF, tag);
        rst       = 1'b0;
        exp_to    = 1'b0;
        exp_stall = '0;
        exp_flush = '0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_to    = 1'b0;
        exp_stall = '0;
        exp_flush = '0;
        idle();
        do_reset("reset0");
        idle();                          step(DEF, "post_reset");

        set_lu(5'd5, 5'd5, 1'b1, 5'd1, 1'b1); step(LU,  "lu_rs1");
        idle();                          step(DEF, "lu_after");
        set_lu(5'd7, 5'd2, 1'b1, 5'd7, 1'b1); step(LU,  "lu_rs2");
        set_lu(5'd5, 5'd5, 1'b0, 5'd1, 1'b1); step(DEF, "lu_nouse");
        set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1); step(DEF, "lu_rd0");
        idle(); hz.mc_done = 1'b1;       step(DEF, "mcdone_run");

        do_reset("reset_mp");
        idle(); hz.ex_mispredict = 1'b1; step(MP,  "mp");
        idle();                          step(DEF, "mp_after");
        hz.ex_mispredict = 1'b1; hz.ex_mc_op = 1'b1;
        set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); step(MP,  "mp_over_mc");
        idle();                          step(DEF, "mp_after2");

        do_reset("reset_mc");
        hz.ex_mc_op = 1'b1;              step(MCS, "mc_start");
        step(MCB, "mc_busy1");
        hz.mem_req = 1'b1;               step(MCB, "mc_busy_memreq");
        hz.mem_req = 1'b0;               step(MCB, "mc_busy3");
        step(MCB, "mc_busy4");
        hz.mc_done = 1'b1;               step(DEF, "mc_done");
        idle();                          step(DEF, "mc_after");

        do_reset("reset_lsu");
        hz.mem_req = 1'b1; hz.ex_mispredict = 1'b1; step(MW, "lsu_w1");
        step(MW, "lsu_w2");
        step(MW, "lsu_w3");
        hz.mem_ready = 1'b1;             step(MP,  "lsu_rel_mp");
        idle();                          step(DEF, "lsu_after");
        hz.mem_req = 1'b1; hz.ex_mc_op = 1'b1; step(MW, "lsu_mc_w");
        hz.mem_ready = 1'b1;             step(MCS, "lsu_rel_mc");
        idle(); hz.ex_mc_op = 1'b1; hz.mc_done = 1'b1; step(DEF, "lsu_mc_done");
        idle(); hz.mem_req = 1'b1;       step(MW,  "lsu_lu_w");
        hz.mem_ready = 1'b1; set_lu(5'd9, 5'd3, 1'b1, 5'd9, 1'b1); step(LU, "lsu_rel_lu");
        idle();                          step(DEF, "lsu_after2");

        do_reset("reset_to");
        hz.mem_req = 1'b1;               step(MW,  "to_enter");
        for (int i = 0; i < 4; i++) begin
            step(MW, "to_wait");
        end
        exp_to = 1'b1;
        step(MW, "to_flag");
        hz.mem_ready = 1'b1;             step(DEF, "to_release");
        idle();                          step(DEF, "to_sticky");
        do_reset("reset_to_clr");
        idle();                          step(DEF, "to_cleared");

        for (int i = 0; i < 10; i++) begin
            set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); step(LU, "sat_lu");
            idle();                      step(DEF, "sat_idle");
        end
        step(DEF, "sat_final");

        hz.ex_mc_op = 1'b1;              step(MCS, "rst_mc_start");
        step(MCB, "rst_mc_busy");
        idle();
        do_reset("reset_mid_mc");
        idle();                          step(DEF, "rst_mc_after");
        hz.ex_mispredict = 1'b1;         step(MP,  "rst_mc_run");
        idle();                          step(DEF, "rst_mc_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
